// File: rtl/disparity_median_filter.sv
// Streaming 3x3 median post-filter for the SGBM disparity stream (raster order, 3-cycle latency).
// Optional build macro DISP_MED_INVALID_EN: keep invalid centres and keep invalid neighbours out of the median.
module disparity_median_filter #(
  parameter int IMG_ROW = 200,
  parameter int IMG_COL = 400,
  parameter int DISP_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_in,
  input  logic [DISP_W-1:0] disp_in,
  input  logic [9:0]        row_in,
  input  logic [9:0]        col_in,
  output logic              valid_out,
  output logic [DISP_W-1:0] disp_out,
  output logic [9:0]        row_out,
  output logic [9:0]        col_out,
  output logic              frame_done
);
  localparam int AW = (IMG_COL > 1) ? $clog2(IMG_COL) : 1;
  localparam logic [9:0] LAST_ROW = 10'(IMG_ROW - 2);
  localparam logic [9:0] LAST_COL = 10'(IMG_COL - 2);
`ifdef DISP_MED_INVALID_EN
  localparam logic [DISP_W-1:0] MARK = '1;
`endif

  // Returns {max, median, min}.
  function automatic logic [3*DISP_W-1:0] sort3(input logic [DISP_W-1:0] a, b, c);
    logic [DISP_W-1:0] lo1, hi1, t;
    lo1 = (a < b) ? a : b;
    hi1 = (a < b) ? b : a;
    t   = (hi1 < c) ? hi1 : c;
    return {((hi1 < c) ? c : hi1), ((lo1 < t) ? t : lo1), ((lo1 < t) ? lo1 : t)};
  endfunction

  function automatic logic [DISP_W-1:0] max3(input logic [DISP_W-1:0] a, b, c);
    logic [3*DISP_W-1:0] s;
    s = sort3(a, b, c);
    return s[3*DISP_W-1:2*DISP_W];
  endfunction

  function automatic logic [DISP_W-1:0] med3(input logic [DISP_W-1:0] a, b, c);
    logic [3*DISP_W-1:0] s;
    s = sort3(a, b, c);
    return s[2*DISP_W-1:DISP_W];
  endfunction

  function automatic logic [DISP_W-1:0] min3(input logic [DISP_W-1:0] a, b, c);
    logic [3*DISP_W-1:0] s;
    s = sort3(a, b, c);
    return s[DISP_W-1:0];
  endfunction

`ifdef DISP_MED_INVALID_EN
  function automatic logic [DISP_W-1:0] scrub(input logic [DISP_W-1:0] v, ctr);
    return (v == MARK) ? ctr : v;
  endfunction
`endif

  logic [DISP_W-1:0] lb0_q [IMG_COL];
  logic [DISP_W-1:0] lb1_q [IMG_COL];
  logic [AW-1:0]     addr;
  logic [DISP_W-1:0] lb0_rd, lb1_rd;

  logic [DISP_W-1:0]   win_q [3][3];
  logic [DISP_W-1:0]   win_d [3][3];
  logic [DISP_W-1:0]   ctr_d;
  logic [3*DISP_W-1:0] srt_d [3];
  logic                emit_d, raw_d;

  logic              vld_p1_q, vld_p2_q;
  logic [DISP_W-1:0] lo_p1_q [3];
  logic [DISP_W-1:0] md_p1_q [3];
  logic [DISP_W-1:0] hi_p1_q [3];
  logic [DISP_W-1:0] ctr_p1_q, ctr_p2_q;
  logic              raw_p1_q, raw_p2_q;
  logic [9:0]        row_p1_q, col_p1_q, row_p2_q, col_p2_q;
  logic [DISP_W-1:0] mxlo_p2_q, mdmd_p2_q, mnhi_p2_q;
  logic [DISP_W-1:0] disp_d;

  logic              valid_out_q, frame_done_q;
  logic [DISP_W-1:0] disp_out_q;
  logic [9:0]        row_out_q, col_out_q;

  // Asynchronous read returns the previous rows before this cycle's write lands.
  assign addr   = col_in[AW-1:0];
  assign lb0_rd = lb0_q[addr];
  assign lb1_rd = lb1_q[addr];

  always_ff @(posedge clk) begin
    if (valid_in) begin
      lb1_q[addr] <= lb0_rd;
      lb0_q[addr] <= disp_in;
    end
  end

  // S1: next window formed combinationally, each column sorted and registered.
  always_comb begin
    for (int k = 0; k < 2; k++)
      for (int j = 0; j < 3; j++)
        win_d[k][j] = win_q[k+1][j];
    win_d[2][0] = lb1_rd;
    win_d[2][1] = lb0_rd;
    win_d[2][2] = disp_in;
    ctr_d = win_d[1][1];
    for (int k = 0; k < 3; k++) begin
`ifdef DISP_MED_INVALID_EN
      srt_d[k] = sort3(scrub(win_d[k][0], ctr_d), scrub(win_d[k][1], ctr_d),
                       scrub(win_d[k][2], ctr_d));
`else
      srt_d[k] = sort3(win_d[k][0], win_d[k][1], win_d[k][2]);
`endif
    end
    emit_d = valid_in && (row_in != 10'd0) && (col_in != 10'd0);
`ifdef DISP_MED_INVALID_EN
    raw_d = (row_in == 10'd1) || (col_in == 10'd1) || (ctr_d == MARK);
`else
    raw_d = (row_in == 10'd1) || (col_in == 10'd1);
`endif
  end

  always_ff @(posedge clk) begin
    if (emit_d) begin
      for (int k = 0; k < 3; k++)
        {hi_p1_q[k], md_p1_q[k], lo_p1_q[k]} <= srt_d[k];
      ctr_p1_q <= ctr_d;
      raw_p1_q <= raw_d;
      row_p1_q <= row_in - 10'd1;
      col_p1_q <= col_in - 10'd1;
    end
    // S2: max of mins, median of medians, min of maxes.
    if (vld_p1_q) begin
      mxlo_p2_q <= max3(lo_p1_q[0], lo_p1_q[1], lo_p1_q[2]);
      mdmd_p2_q <= med3(md_p1_q[0], md_p1_q[1], md_p1_q[2]);
      mnhi_p2_q <= min3(hi_p1_q[0], hi_p1_q[1], hi_p1_q[2]);
      ctr_p2_q  <= ctr_p1_q;
      raw_p2_q  <= raw_p1_q;
      row_p2_q  <= row_p1_q;
      col_p2_q  <= col_p1_q;
    end
  end

  // S3: final median, or the raw centre for border / invalid centres.
  assign disp_d = raw_p2_q ? ctr_p2_q : med3(mxlo_p2_q, mdmd_p2_q, mnhi_p2_q);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < 3; k++)
        for (int j = 0; j < 3; j++)
          win_q[k][j] <= '0;
      vld_p1_q     <= 1'b0;
      vld_p2_q     <= 1'b0;
      valid_out_q  <= 1'b0;
      frame_done_q <= 1'b0;
      disp_out_q   <= '0;
      row_out_q    <= '0;
      col_out_q    <= '0;
    end else begin
      if (valid_in)
        for (int k = 0; k < 3; k++)
          for (int j = 0; j < 3; j++)
            win_q[k][j] <= win_d[k][j];
      vld_p1_q     <= emit_d;
      vld_p2_q     <= vld_p1_q;
      valid_out_q  <= vld_p2_q;
      frame_done_q <= vld_p2_q && (row_p2_q == LAST_ROW) && (col_p2_q == LAST_COL);
      if (vld_p2_q) begin
        disp_out_q <= disp_d;
        row_out_q  <= row_p2_q;
        col_out_q  <= col_p2_q;
      end
    end
  end

  assign valid_out  = valid_out_q;
  assign disp_out   = disp_out_q;
  assign row_out    = row_out_q;
  assign col_out    = col_out_q;
  assign frame_done = frame_done_q;
endmodule

// File: tb/tb_disparity_median_filter.sv
// Directed bench for disparity_median_filter on an 8x8 image.
module tb_disparity_median_filter;
  localparam int R = 8;
  localparam int C = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       valid_in = 1'b0;
  logic [7:0] disp_in = 8'd0;
  logic [9:0] row_in = 10'd0;
  logic [9:0] col_in = 10'd0;
  logic       valid_out, frame_done;
  logic [7:0] disp_out;
  logic [9:0] row_out, col_out;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  logic [7:0] img   [R][C];
  logic [7:0] out_d [R][C];
  int         out_c [R][C];
  int         trig  [R][C];
  int out_cnt = 0, fd_cnt = 0, fd_bad = 0, lat_err = 0;
  int fd_row = -1, fd_col = -1;

  disparity_median_filter #(.IMG_ROW(R), .IMG_COL(C), .DISP_W(8)) dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .disp_in(disp_in),
    .row_in(row_in), .col_in(col_in), .valid_out(valid_out),
    .disp_out(disp_out), .row_out(row_out), .col_out(col_out),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Output recorder: value and arrival cycle per centre, latency against the trigger pixel.
  always @(negedge clk) begin
    int ro, co;
    ro = int'(row_out);
    co = int'(col_out);
    if (valid_out) begin
      out_cnt++;
      if (ro < R - 1 && co < C - 1) begin
        out_d[ro][co] = disp_out;
        out_c[ro][co] = cyc;
        if (cyc - trig[ro+1][co+1] != 3) lat_err++;
      end
    end
    if (frame_done) begin
      fd_cnt++;
      fd_row = ro;
      fd_col = co;
      if (!valid_out) fd_bad++;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, tests=%0d", tests);
    $fatal(1, "watchdog");
  end

  task automatic pix(input logic [7:0] d, input int r, input int c, input int gap);
    @(negedge clk);
    valid_in = 1'b1;
    disp_in  = d;
    row_in   = 10'(r);
    col_in   = 10'(c);
    trig[r][c] = cyc;
    if (gap > 1) begin
      @(negedge clk);
      valid_in = 1'b0;
      repeat (gap - 2) @(negedge clk);
    end
  endtask

  task automatic idle(input int n);
    @(negedge clk);
    valid_in = 1'b0;
    repeat (n - 1) @(negedge clk);
  endtask

  task automatic send_frame(input int gap);
    for (int r = 0; r < R; r++)
      for (int c = 0; c < C; c++)
        pix(img[r][c], r, c, gap);
  endtask

  task automatic fill(input logic [7:0] v);
    for (int r = 0; r < R; r++)
      for (int c = 0; c < C; c++)
        img[r][c] = v;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      valid_in = ~valid_in;
      disp_in  = 8'(i * 37 + 5);
      row_in   = 10'(i + 2);
      col_in   = 10'(i + 2);
      tests++; if (valid_out !== 1'b0) begin fails++; $display("FAIL reset_valid cyc%0d got %b want 0", i, valid_out); end
      tests++; if (disp_out !== 8'd0) begin fails++; $display("FAIL reset_disp cyc%0d got %0d want 0", i, disp_out); end
      tests++; if (row_out !== 10'd0 || col_out !== 10'd0) begin fails++; $display("FAIL reset_coord cyc%0d got (%0d,%0d) want (0,0)", i, row_out, col_out); end
      tests++; if (frame_done !== 1'b0) begin fails++; $display("FAIL reset_fd cyc%0d got %b want 0", i, frame_done); end
    end
    @(negedge clk);
    valid_in = 1'b0;
    rst = 1'b1;
    idle(4);
    tests++; if (out_cnt !== 0) begin fails++; $display("FAIL reset_no_output got %0d outputs want 0", out_cnt); end
  endtask

  task automatic test_constant();
    int b_cnt, b_fd, b_lat, bad;
    fill(8'd20);
    b_cnt = out_cnt; b_fd = fd_cnt; b_lat = lat_err;
    send_frame(1);
    idle(6);
    bad = 0;
    for (int r = 0; r < R - 1; r++)
      for (int c = 0; c < C - 1; c++)
        if (out_d[r][c] !== 8'd20) bad++;
    tests++; if (out_cnt - b_cnt !== 49) begin fails++; $display("FAIL const_count got %0d want 49", out_cnt - b_cnt); end
    tests++; if (bad !== 0) begin fails++; $display("FAIL const_values got %0d non-20 outputs want 0", bad); end
    tests++; if (lat_err - b_lat !== 0) begin fails++; $display("FAIL const_latency got %0d late outputs want 0", lat_err - b_lat); end
    tests++; if (fd_cnt - b_fd !== 1) begin fails++; $display("FAIL const_fd_count got %0d want 1", fd_cnt - b_fd); end
    tests++; if (fd_row !== 6 || fd_col !== 6) begin fails++; $display("FAIL const_fd_pos got (%0d,%0d) want (6,6)", fd_row, fd_col); end
    tests++; if (fd_bad !== 0) begin fails++; $display("FAIL const_fd_strobe got %0d unaligned want 0", fd_bad); end
  endtask

  task automatic test_salt();
    int b_cnt, bad;
    fill(8'd10);
    img[3][3] = 8'd90;
    b_cnt = out_cnt;
    send_frame(1);
    idle(6);
    bad = 0;
    for (int r = 0; r < R - 1; r++)
      for (int c = 0; c < C - 1; c++)
        if (out_d[r][c] !== 8'd10) bad++;
    tests++; if (out_d[3][3] !== 8'd10) begin fails++; $display("FAIL salt_centre got %0d want 10", out_d[3][3]); end
    tests++; if (bad !== 0) begin fails++; $display("FAIL salt_all got %0d non-10 outputs want 0", bad); end
    tests++; if (out_cnt - b_cnt !== 49) begin fails++; $display("FAIL salt_count got %0d want 49", out_cnt - b_cnt); end
  endtask

  task automatic test_sparse();
    int b_lat, bad;
    for (int r = 0; r < R; r++)
      for (int c = 0; c < C; c++)
        img[r][c] = 8'(c * 4);
    b_lat = lat_err;
    send_frame(13);
    idle(6);
    bad = 0;
    for (int r = 0; r < R - 1; r++)
      for (int c = 0; c < C - 2; c++)
        if (out_c[r][c+1] - out_c[r][c] != 13) bad++;
    tests++; if (out_d[2][2] !== 8'd8) begin fails++; $display("FAIL sparse_centre got %0d want 8", out_d[2][2]); end
    tests++; if (out_d[0][5] !== 8'd20) begin fails++; $display("FAIL sparse_border got %0d want 20", out_d[0][5]); end
    tests++; if (out_d[3][4] !== 8'd16) begin fails++; $display("FAIL sparse_inner got %0d want 16", out_d[3][4]); end
    tests++; if (bad !== 0) begin fails++; $display("FAIL sparse_spacing got %0d gaps not 13 want 0", bad); end
    tests++; if (lat_err - b_lat !== 0) begin fails++; $display("FAIL sparse_latency got %0d late outputs want 0", lat_err - b_lat); end
  endtask

  task automatic test_invalid();
    logic [7:0] exp_a33, exp_b22;
`ifdef DISP_MED_INVALID_EN
    exp_a33 = 8'hFF;
    exp_b22 = 8'hFF;
`else
    exp_a33 = 8'd30;
    exp_b22 = 8'd30;
`endif
    fill(8'd30);
    img[3][3] = 8'hFF;
    send_frame(1);
    idle(6);
    tests++; if (out_d[3][3] !== exp_a33) begin fails++; $display("FAIL inv_centre got %0h want %0h", out_d[3][3], exp_a33); end
    tests++; if (out_d[2][2] !== 8'd30) begin fails++; $display("FAIL inv_near_centre got %0d want 30", out_d[2][2]); end
    fill(8'd30);
    img[2][2] = 8'hFF;
    send_frame(1);
    idle(6);
    tests++; if (out_d[3][3] !== 8'd30) begin fails++; $display("FAIL inv_neighbour got %0d want 30", out_d[3][3]); end
    tests++; if (out_d[2][2] !== exp_b22) begin fails++; $display("FAIL inv_own got %0h want %0h", out_d[2][2], exp_b22); end
    fill(8'd30);
    img[2][2] = 8'hFF; img[2][3] = 8'hFF; img[2][4] = 8'hFF;
    img[3][2] = 8'hFF; img[3][3] = 8'hFF;
    send_frame(1);
    idle(6);
    tests++; if (out_d[3][3] !== 8'hFF) begin fails++; $display("FAIL inv_five got %0h want ff", out_d[3][3]); end
    tests++; if (out_d[2][3] !== 8'hFF) begin fails++; $display("FAIL inv_five_up got %0h want ff", out_d[2][3]); end
    tests++; if (out_d[3][4] !== 8'd30) begin fails++; $display("FAIL inv_three got %0d want 30", out_d[3][4]); end
    tests++; if (out_d[4][4] !== 8'd30) begin fails++; $display("FAIL inv_one got %0d want 30", out_d[4][4]); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] f1 [R][C];
    logic [7:0] f2 [R][C];
    int b_cnt, b_fd, b_lat, bad, diff;
    for (int r = 0; r < R; r++)
      for (int c = 0; c < C; c++)
        img[r][c] = 8'(r * 10 + c);
    b_cnt = out_cnt; b_fd = fd_cnt; b_lat = lat_err;
    for (int k = 0; k < 2; k++)
      for (int r = 0; r < R; r++)
        for (int c = 0; c < C; c++) begin
          pix(img[r][c], r, c, 1);
          if (k == 1 && r == 0 && c == 4) f1 = out_d;
        end
    idle(6);
    f2 = out_d;
    bad = 0; diff = 0;
    for (int r = 0; r < R - 1; r++)
      for (int c = 0; c < C - 1; c++) begin
        if (f1[r][c] !== 8'(r * 10 + c)) bad++;
        if (f1[r][c] !== f2[r][c]) diff++;
      end
    tests++; if (out_cnt - b_cnt !== 98) begin fails++; $display("FAIL b2b_count got %0d want 98", out_cnt - b_cnt); end
    tests++; if (fd_cnt - b_fd !== 2) begin fails++; $display("FAIL b2b_fd got %0d want 2", fd_cnt - b_fd); end
    tests++; if (f1[5][3] !== 8'd53) begin fails++; $display("FAIL b2b_pixel got %0d want 53", f1[5][3]); end
    tests++; if (bad !== 0) begin fails++; $display("FAIL b2b_values got %0d wrong want 0", bad); end
    tests++; if (diff !== 0) begin fails++; $display("FAIL b2b_frames got %0d differing want 0", diff); end
    tests++; if (lat_err - b_lat !== 0) begin fails++; $display("FAIL b2b_latency got %0d late want 0", lat_err - b_lat); end

    // Frame 3 aborted by a short reset pulse just after pixel (4,2).
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < C; c++)
        if (r < 4 || c <= 2) pix(img[r][c], r, c, 1);
    @(negedge clk);
    valid_in = 1'b0;
    rst = 1'b0;
    #2 rst = 1'b1;
    @(negedge clk);
    tests++; if (valid_out !== 1'b0) begin fails++; $display("FAIL midrst_drop1 got %b want 0", valid_out); end
    @(negedge clk);
    tests++; if (valid_out !== 1'b0) begin fails++; $display("FAIL midrst_drop2 got %b want 0", valid_out); end
    idle(3);
    b_cnt = out_cnt;
    send_frame(1);
    idle(6);
    diff = 0;
    for (int r = 0; r < R - 1; r++)
      for (int c = 0; c < C - 1; c++)
        if (out_d[r][c] !== f1[r][c]) diff++;
    tests++; if (out_cnt - b_cnt !== 49) begin fails++; $display("FAIL midrst_count got %0d want 49", out_cnt - b_cnt); end
    tests++; if (diff !== 0) begin fails++; $display("FAIL midrst_frame got %0d differing want 0", diff); end
  endtask

  initial begin
    test_reset();
    test_constant();
    test_salt();
    test_sparse();
    test_invalid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
